// File: rtl/fpu_issue_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | fpu_issue_arbiter_pkg : shared FP16 types and arbiter FSM states     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package fpu_issue_arbiter_pkg;

  localparam int FP16_W = 16;
  localparam int FLAG_W = 3;
  localparam int OP_W   = 2;

  typedef logic [FP16_W-1:0] fp16_t;
  // Flag bit order is {OF, UF, NX}.
  typedef logic [FLAG_W-1:0] opStatusFlag_t;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_ILL = 2'd3
  } fpuOp_t;

  localparam fp16_t FP16_QNAN = 16'h7E00;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/fpu_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | fpu_rr_arbiter : combinational round-robin, first valid at/after ptr |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fpu_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W:0] sum;
  logic           found;

  // One wrap subtraction suffices because ptr is always below NREQ.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NREQ)) begin
        sum = sum - (IDX_W+1)'(NREQ);
      end
      if (!found && req[sum[IDX_W-1:0]]) begin
        grant[sum[IDX_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu_issue_arbiter.sv
// +----------------------------------------------------------------------+
// | fpu_issue_arbiter : shares one pipelined FP16 datapath among NREQ    |
// | requesters with result routing, sticky flags and flush/drain.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fpu_issue_arbiter
  import fpu_issue_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     reqValid,
  output logic [NREQ-1:0]     reqReady,
  input  logic [2*NREQ-1:0]   reqOp,
  input  logic [16*NREQ-1:0]  reqA,
  input  logic [16*NREQ-1:0]  reqB,
  output logic                dpValid,
  output logic [1:0]          dpOp,
  output logic [15:0]         dpA,
  output logic [15:0]         dpB,
  input  logic [15:0]         dpResult,
  input  logic [2:0]          dpFlags,
  output logic [NREQ-1:0]     rspValid,
  output logic [15:0]         rspResult,
  output logic [2:0]          rspFlags,
  output logic [3*NREQ-1:0]   accFlags,
  input  logic [NREQ-1:0]     clearFlags,
  input  logic                flushReq,
  output logic                flushDone
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(LAT+1);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [LAT-1:0]    pipe_vld_q, pipe_vld_d;
  logic [LAT-1:0]    pipe_ill_q, pipe_ill_d;
  logic [IDX_W-1:0]  pipe_tag_q [LAT];
  logic [IDX_W-1:0]  pipe_tag_d [LAT];
  logic [CNT_W-1:0]  in_flight_q, in_flight_d;
  logic [3*NREQ-1:0] acc_flags_q, acc_flags_d;

  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic [1:0]        sel_op;
  fp16_t             sel_a, sel_b;
  logic              accept_en, accept, sel_illegal, tail_vld, flush_done;

  fpu_rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req   (reqValid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  always_comb begin
    grant_idx = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_idx = IDX_W'(i);
        sel_op    = reqOp[2*i +: 2];
        sel_a     = reqA[16*i +: 16];
        sel_b     = reqB[16*i +: 16];
      end
    end
  end

  assign accept_en   = (state_q == ST_RUN) && !reset;
  assign reqReady    = accept_en ? grant : '0;
  assign accept      = accept_en && (|reqValid);
  assign sel_illegal = (sel_op == OP_ILL);

  // Illegal ops are consumed and tracked but never reach the datapath.
  assign dpValid = accept && !sel_illegal;
  assign dpOp    = dpValid ? sel_op : '0;
  assign dpA     = dpValid ? sel_a  : '0;
  assign dpB     = dpValid ? sel_b  : '0;

  assign tail_vld = pipe_vld_q[LAT-1] && !reset;

  always_comb begin
    rspValid  = '0;
    rspResult = '0;
    rspFlags  = '0;
    if (tail_vld) begin
      rspValid[pipe_tag_q[LAT-1]] = 1'b1;
      rspResult = pipe_ill_q[LAT-1] ? FP16_QNAN : dpResult;
      rspFlags  = pipe_ill_q[LAT-1] ? 3'b000    : dpFlags;
    end
  end

  always_comb begin
    pipe_vld_d    = '0;
    pipe_ill_d    = '0;
    pipe_vld_d[0] = accept;
    pipe_ill_d[0] = accept && sel_illegal;
    pipe_tag_d[0] = grant_idx;
    for (int k = 1; k < LAT; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_ill_d[k] = pipe_ill_q[k-1];
      pipe_tag_d[k] = pipe_tag_q[k-1];
    end
  end

  always_comb begin
    in_flight_d = in_flight_q;
    case ({accept, tail_vld})
      2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
      2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  // A clear coinciding with a response keeps that response's flags.
  always_comb begin
    acc_flags_d = acc_flags_q;
    for (int i = 0; i < NREQ; i++) begin
      if (clearFlags[i]) begin
        acc_flags_d[3*i +: 3] = {3{rspValid[i]}} & rspFlags;
      end else begin
        acc_flags_d[3*i +: 3] = acc_flags_q[3*i +: 3] | ({3{rspValid[i]}} & rspFlags);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == IDX_W'(NREQ-1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // Drain ends on the cycle the last outstanding response retires
  // (no accepts happen in DRAIN, so in_flight_d reflects only retirement).
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (flushReq) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (in_flight_d == '0) begin
          state_d    = ST_RUN;
          flush_done = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign flushDone = flush_done && !reset;
  assign accFlags  = acc_flags_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      rr_ptr_q    <= '0;
      pipe_vld_q  <= '0;
      pipe_ill_q  <= '0;
      in_flight_q <= '0;
      acc_flags_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        pipe_tag_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_ill_q  <= pipe_ill_d;
      in_flight_q <= in_flight_d;
      acc_flags_q <= acc_flags_d;
      pipe_tag_q  <= pipe_tag_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_issue_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_fpu_issue_arbiter : directed self-checking bench, NREQ=2, LAT=3   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fpu_issue_arbiter;

  localparam int NREQ = 2;
  localparam int LAT  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  reqValid = '0;
  logic [1:0]  reqReady;
  logic [3:0]  reqOp = '0;
  logic [31:0] reqA = '0;
  logic [31:0] reqB = '0;
  logic        dpValid;
  logic [1:0]  dpOp;
  logic [15:0] dpA, dpB;
  logic [15:0] dpResult = '0;
  logic [2:0]  dpFlags = '0;
  logic [1:0]  rspValid;
  logic [15:0] rspResult;
  logic [2:0]  rspFlags;
  logic [5:0]  accFlags;
  logic [1:0]  clearFlags = '0;
  logic        flushReq = 1'b0;
  logic        flushDone;

  int n_pass  = 0;
  int n_total = 0;

  fpu_issue_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqOp      (reqOp),
    .reqA       (reqA),
    .reqB       (reqB),
    .dpValid    (dpValid),
    .dpOp       (dpOp),
    .dpA        (dpA),
    .dpB        (dpB),
    .dpResult   (dpResult),
    .dpFlags    (dpFlags),
    .rspValid   (rspValid),
    .rspResult  (rspResult),
    .rspFlags   (rspFlags),
    .accFlags   (accFlags),
    .clearFlags (clearFlags),
    .flushReq   (flushReq),
    .flushDone  (flushDone)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_reqReady", reqReady, 2'b00);
    chk("rst_dpValid", dpValid, 1'b0);
    chk("rst_rspValid", rspValid, 2'b00);
    chk("rst_accFlags", accFlags, 6'd0);
    chk("rst_flushDone", flushDone, 1'b0);

    // 1: single ADD from req0, response exactly LAT cycles after accept
    reqValid = 2'b01;
    reqOp    = 4'b0000;
    reqA     = {16'h0000, 16'h3C00};
    reqB     = {16'h0000, 16'h3C00};
    #1;
    chk("t1_reqReady", reqReady, 2'b01);
    chk("t1_dpValid", dpValid, 1'b1);
    chk("t1_dpOp", dpOp, 2'd0);
    chk("t1_dpA", dpA, 16'h3C00);
    chk("t1_dpB", dpB, 16'h3C00);
    tick();
    reqValid = 2'b00;
    #1;
    chk("t1_rsp_lat1", rspValid, 2'b00);
    tick();
    chk("t1_rsp_lat2", rspValid, 2'b00);
    tick();
    dpResult = 16'h4000;
    dpFlags  = 3'b000;
    #1;
    chk("t1_rspValid", rspValid, 2'b01);
    chk("t1_rspResult", rspResult, 16'h4000);
    chk("t1_rspFlags", rspFlags, 3'b000);
    tick();

    // 3: illegal op from req1 (also moves the pointer back to 0)
    reqValid = 2'b10;
    reqOp    = 4'b1100;
    #1;
    chk("t3_reqReady", reqReady, 2'b10);
    chk("t3_dpValid", dpValid, 1'b0);
    tick();
    reqValid = 2'b00;
    reqOp    = 4'b0000;
    tick();
    tick();
    dpResult = 16'h1234;
    dpFlags  = 3'b111;
    #1;
    chk("t3_rspValid", rspValid, 2'b10);
    chk("t3_rspResult", rspResult, 16'h7E00);
    chk("t3_rspFlags", rspFlags, 3'b000);
    tick();
    dpFlags = 3'b000;
    #1;
    chk("t3_accFlags1", accFlags[5:3], 3'b000);

    // 2: both requesters valid for 4 cycles, grants alternate from req0
    reqA = {16'h2000, 16'h1000};
    for (int k = 0; k < 7; k++) begin
      reqValid = (k < 4) ? 2'b11 : 2'b00;
      dpResult = 16'hA000 + 16'(k);
      #1;
      if (k < 4) begin
        chk("t2_reqReady", reqReady, (k % 2 == 0) ? 2'b01 : 2'b10);
        chk("t2_dpValid", dpValid, 1'b1);
        chk("t2_dpA", dpA, (k % 2 == 0) ? 16'h1000 : 16'h2000);
      end else begin
        chk("t2_dpValid_idle", dpValid, 1'b0);
      end
      if (k >= 3) begin
        chk("t2_rspValid", rspValid, ((k - 3) % 2 == 0) ? 2'b01 : 2'b10);
        chk("t2_rspResult", rspResult, 16'hA000 + 16'(k));
      end else begin
        chk("t2_rspValid_none", rspValid, 2'b00);
      end
      tick();
    end

    // 4: sticky flags, then clear together with a new response
    for (int k = 0; k < 6; k++) begin
      reqValid   = (k < 3) ? 2'b01 : 2'b00;
      dpFlags    = (k == 3) ? 3'b001 : (k == 4) ? 3'b100 : (k == 5) ? 3'b010 : 3'b000;
      clearFlags = (k == 5) ? 2'b01 : 2'b00;
      #1;
      if (k == 4) chk("t4_acc_after1", accFlags[2:0], 3'b001);
      if (k == 5) begin
        chk("t4_acc_after2", accFlags[2:0], 3'b101);
        chk("t4_rspValid", rspValid, 2'b01);
      end
      tick();
    end
    clearFlags = 2'b00;
    dpFlags    = 3'b000;
    #1;
    chk("t4_acc_clear_with_rsp", accFlags[2:0], 3'b010);
    clearFlags = 2'b01;
    tick();
    clearFlags = 2'b00;
    #1;
    chk("t4_acc_clear_alone", accFlags[2:0], 3'b000);

    // 5: three back-to-back ops, flush on the third accept
    reqValid = 2'b01;
    for (int k = 0; k < 8; k++) begin
      flushReq = (k == 2) || (k == 3);
      dpResult = 16'hB000 + 16'(k);
      #1;
      chk("t5_reqReady", reqReady, (k < 3 || k >= 6) ? 2'b01 : 2'b00);
      chk("t5_flushDone", flushDone, (k == 5) ? 1'b1 : 1'b0);
      chk("t5_rspValid", rspValid, (k >= 3 && k <= 5) ? 2'b01 : 2'b00);
      tick();
    end

    // 6: reset with two ops in flight
    reqValid = 2'b00;
    flushReq = 1'b0;
    reset    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("t6_rspValid_a", rspValid, 2'b00);
    chk("t6_accFlags", accFlags, 6'd0);
    chk("t6_inFlight", dut.in_flight_q, 0);
    tick();
    chk("t6_rspValid_b", rspValid, 2'b00);
    reqValid = 2'b11;
    #1;
    chk("t6_first_grant", reqReady, 2'b01);
    reqValid = 2'b00;

    // flush with an empty pipe completes one cycle later
    flushReq = 1'b1;
    #1;
    chk("fe_flushDone_req", flushDone, 1'b0);
    tick();
    flushReq = 1'b0;
    #1;
    chk("fe_flushDone", flushDone, 1'b1);
    tick();
    reqValid = 2'b01;
    #1;
    chk("fe_flushDone_clr", flushDone, 1'b0);
    chk("fe_run_reqReady", reqReady, 2'b01);
    reqValid = 2'b00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
